frac_baud_generator: RTL

Programmable fractional-N baud tick generator, the successor of the fixed-divisor generator in the UART datapath. It produces an oversample tick whose average period is div_int + div_frac/2^DIV_FRAC_W clock cycles. It also produces a bit tick every OVERSAMPLE oversample ticks and a mid-bit tick for receiver sampling. The divisor is runtime-loadable with glitch-free changeover, and a phase restart lets the receiver align to a start-bit edge.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/frac_phase_acc.sv | 77 +++++++
 rtl/frac_baud_generator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration-time divisor calculation.
package uart_pkg;

  // Shortest legal period; anything below this would make os_tick continuous.
  localparam int unsigned MIN_DIV = 2;

  localparam longint unsigned DEFAULT_CLK_FREQ   = 100_000_000;
  localparam longint unsigned DEFAULT_BAUD       = 115_200;
  localparam int unsigned     DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned     DEFAULT_DIV_FRAC_W = 4;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } div_pair_t;

  // Rounded fixed-point divisor clk_freq / (baud * oversample), split into
  // integer and fractional parts with frac_w fractional bits.
  function automatic div_pair_t calc_div(input longint unsigned clk_freq,
                                         input longint unsigned baud,
                                         input int unsigned     oversample,
                                         input int unsigned     frac_w);
    longint unsigned den;
    longint unsigned scaled;
    div_pair_t       res;
    den          = baud * longint'(oversample);
    scaled       = ((clk_freq << frac_w) + den / 2) / den;
    res.div_int  = 32'(scaled >> frac_w);
    res.div_frac = 32'(scaled & ((64'd1 << frac_w) - 64'd1));
    return res;
  endfunction

  // 100 MHz / (115200 * 16) = 54.25 -> {54, 4/16}
  localparam div_pair_t DEFAULT_DIV =
    calc_div(DEFAULT_CLK_FREQ, DEFAULT_BAUD, DEFAULT_OVERSAMPLE, DEFAULT_DIV_FRAC_W);
  localparam int unsigned DEFAULT_DIV_INT  = DEFAULT_DIV.div_int;
  localparam int unsigned DEFAULT_DIV_FRAC = DEFAULT_DIV.div_frac;

endpackage

// File: rtl/frac_phase_acc.sv
// Period engine: counts one os_tick period of length act_int + carry and
// advances the fractional accumulator at every period end.
module frac_phase_acc
  import uart_pkg::*;
#(
  parameter int DIV_INT_W     = 16,
  parameter int DIV_FRAC_W    = 4,
  parameter int RESET_DIV_INT = 54
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  restart_int,  // integer divisor for the period after restart
  input  logic [DIV_INT_W-1:0]  next_int,     // integer divisor for the period after period_end
  input  logic [DIV_FRAC_W-1:0] frac,         // fraction added at period_end
  output logic                  period_end
);

  localparam logic [DIV_INT_W-1:0] RESET_LEN =
    DIV_INT_W'((RESET_DIV_INT < int'(MIN_DIV)) ? int'(MIN_DIV) : RESET_DIV_INT);

  function automatic logic [DIV_INT_W-1:0] clamp_int(input logic [DIV_INT_W-1:0] v);
    return (v < DIV_INT_W'(MIN_DIV)) ? DIV_INT_W'(MIN_DIV) : v;
  endfunction

  logic [DIV_INT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [DIV_INT_W-1:0]  len_q, len_d;     // clamped integer length latched at period start
  logic [DIV_INT_W-1:0]  last_cnt;
  logic [DIV_FRAC_W:0]   acc_sum;

  // len_q >= MIN_DIV, so len_q - 1 + carry never wraps.
  assign last_cnt   = len_q - DIV_INT_W'(1) + DIV_INT_W'(carry_q);
  assign period_end = enable && !restart && (cnt_q == last_cnt);

  // Next-state: restart re-phases, period end reloads, otherwise count.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    len_d   = len_q;
    acc_sum = {1'b0, acc_q} + {1'b0, frac};
    if (restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      len_d   = clamp_int(restart_int);
    end else if (period_end) begin
      cnt_d            = '0;
      {carry_d, acc_d} = acc_sum;
      len_d            = clamp_int(next_int);
    end else if (enable) begin
      cnt_d = cnt_q + DIV_INT_W'(1);
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      len_q   <= RESET_LEN;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: rtl/frac_baud_generator.sv
// Fractional-N baud tick generator: divisor load/pending logic, oversample
// phase counter and registered tick decode around the period engine.
module frac_baud_generator
  import uart_pkg::*;
#(
  parameter int DIV_INT_W      = 16,
  parameter int DIV_FRAC_W     = 4,
  parameter int OVERSAMPLE     = 16,   // power of two, >= 4
  parameter int RESET_DIV_INT  = int'(DEFAULT_DIV_INT),
  parameter int RESET_DIV_FRAC = int'(DEFAULT_DIV_FRAC),
  localparam int PHASE_W       = $clog2(OVERSAMPLE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  div_load,
  output logic                  div_pending,
  output logic                  os_tick,
  output logic                  mid_tick,
  output logic                  bit_tick,
  output logic [PHASE_W-1:0]    os_phase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PRE_MID    = PHASE_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_INT_W-1:0]  act_int_q,  act_int_d;
  logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_INT_W-1:0]  pend_int_q, pend_int_d;
  logic [DIV_FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic                  div_pending_q, div_pending_d;
  logic [PHASE_W-1:0]    os_phase_q, os_phase_d;
  logic                  os_tick_q, os_tick_d;
  logic                  mid_tick_q, mid_tick_d;
  logic                  bit_tick_q, bit_tick_d;

  logic                  period_end;
  logic [DIV_INT_W-1:0]  restart_int;
  logic [DIV_INT_W-1:0]  next_int;

  // A load coinciding with restart governs the very first re-phased period.
  assign restart_int = div_load ? div_int : act_int_q;
  // At a boundary the pending divisor, if any, governs the next period.
  assign next_int    = div_pending_q ? pend_int_q : act_int_q;

  frac_phase_acc #(
    .DIV_INT_W     (DIV_INT_W),
    .DIV_FRAC_W    (DIV_FRAC_W),
    .RESET_DIV_INT (RESET_DIV_INT)
  ) u_phase_acc (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .restart     (restart),
    .restart_int (restart_int),
    .next_int    (next_int),
    .frac        (act_frac_q),   // carry of the ending period uses the old fraction
    .period_end  (period_end)
  );

  // Divisor changeover, phase advance and tick decode.
  always_comb begin
    act_int_d     = act_int_q;
    act_frac_d    = act_frac_q;
    pend_int_d    = pend_int_q;
    pend_frac_d   = pend_frac_q;
    div_pending_d = div_pending_q;
    os_phase_d    = os_phase_q;
    os_tick_d     = 1'b0;
    mid_tick_d    = 1'b0;
    bit_tick_d    = 1'b0;

    if (restart) begin
      os_phase_d = '0;
      if (div_load) begin
        act_int_d     = div_int;
        act_frac_d    = div_frac;
        div_pending_d = 1'b0;
      end
    end else begin
      if (period_end) begin
        os_tick_d  = 1'b1;
        bit_tick_d = (os_phase_q == LAST_PHASE);
        mid_tick_d = (os_phase_q == PRE_MID);
        os_phase_d = os_phase_q + PHASE_W'(1);
        if (div_pending_q) begin
          act_int_d     = pend_int_q;
          act_frac_d    = pend_frac_q;
          div_pending_d = 1'b0;
        end
      end
      // A load in the boundary cycle queues behind the swap just made.
      if (div_load) begin
        if (enable) begin
          pend_int_d    = div_int;
          pend_frac_d   = div_frac;
          div_pending_d = 1'b1;
        end else begin
          act_int_d     = div_int;
          act_frac_d    = div_frac;
          div_pending_d = 1'b0;
        end
      end
    end
  end

  // Divisor, phase and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int_q     <= DIV_INT_W'(RESET_DIV_INT);
      act_frac_q    <= DIV_FRAC_W'(RESET_DIV_FRAC);
      pend_int_q    <= '0;
      pend_frac_q   <= '0;
      div_pending_q <= 1'b0;
      os_phase_q    <= '0;
      os_tick_q     <= 1'b0;
      mid_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
    end else begin
      act_int_q     <= act_int_d;
      act_frac_q    <= act_frac_d;
      pend_int_q    <= pend_int_d;
      pend_frac_q   <= pend_frac_d;
      div_pending_q <= div_pending_d;
      os_phase_q    <= os_phase_d;
      os_tick_q     <= os_tick_d;
      mid_tick_q    <= mid_tick_d;
      bit_tick_q    <= bit_tick_d;
    end
  end

  assign div_pending = div_pending_q;
  assign os_tick     = os_tick_q;
  assign mid_tick    = mid_tick_q;
  assign bit_tick    = bit_tick_q;
  assign os_phase    = os_phase_q;

endmodule
